// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared widths, constants and the fetch-entry type used by the
//               instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0]  PC_STEP   = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/instruction_fetch_if.sv
// ============================================================================
// Module      : instruction_fetch_if
// Description : Instruction-memory bus plus the decode valid/ready handshake.
//               master = fetch stage, slave = memory/decode side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instruction_fetch_if;
    import fetch_pkg::*;

    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               dec_valid;
    logic               dec_ready;
    logic [INSTR_W-1:0] dec_instr;
    logic [ADDR_W-1:0]  dec_pc;
    logic [ADDR_W-1:0]  dec_pc_plus4;

    modport master (
        output imem_addr,
        input  imem_data,
        output dec_valid,
        input  dec_ready,
        output dec_instr,
        output dec_pc,
        output dec_pc_plus4
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  dec_valid,
        output dec_ready,
        input  dec_instr,
        input  dec_pc,
        input  dec_pc_plus4
    );

endinterface : instruction_fetch_if

`default_nettype wire

// File: rtl/fetch_skid_buffer.sv
// ============================================================================
// Module      : fetch_skid_buffer
// Description : Two-entry output register plus skid slot with push, pop,
//               flush and a valid/ready output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_skid_buffer
    import fetch_pkg::*;
(
    input  wire logic         clock,
    input  wire logic         reset,
    input  wire logic         flush_i,
    input  wire logic         push_i,
    input  wire fetch_entry_t push_data_i,
    input  wire logic         ready_i,
    output logic              valid_o,
    output fetch_entry_t      data_o,
    output logic              skid_valid_o
);

    logic         out_valid_q,  out_valid_d;
    fetch_entry_t out_q,        out_d;
    logic         skid_valid_q, skid_valid_d;
    fetch_entry_t skid_q,       skid_d;
    logic         w_pop;

    assign w_pop = out_valid_q && ready_i;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || w_pop) begin
            // The skid is always older than an incoming word.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_d        = skid_q;
                skid_valid_d = push_i;
                if (push_i) begin
                    skid_d = push_data_i;
                end
            end else begin
                out_valid_d = push_i;
                if (push_i) begin
                    out_d = push_data_i;
                end
            end
        end else if (push_i) begin
            skid_valid_d = 1'b1;
            skid_d       = push_data_i;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_q        <= '{instr: NOP_INSTR, pc: '0};
            skid_valid_q <= 1'b0;
            skid_q       <= '{instr: NOP_INSTR, pc: '0};
        end else begin
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end

    assign valid_o      = out_valid_q;
    assign data_o       = out_q;
    assign skid_valid_o = skid_valid_q;

endmodule : fetch_skid_buffer

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// Module      : instruction_fetch
// Description : PC, issue/occupancy control and redirect handling in front of
//               a one-cycle-latency instruction memory. Optional alignment and
//               range fault check enabled by macro FETCH_FAULT_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter int                MEM_BYTES = 16
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              fetch_en,
    input  wire logic              redirect_valid,
    input  wire logic [ADDR_W-1:0] redirect_pc,
    instruction_fetch_if.master    bus
`ifdef FETCH_FAULT_CHECK_EN
    ,
    output logic                   fetch_fault
`endif
);

    logic [ADDR_W-1:0] pc_q,     pc_d;
    logic              req_q,    req_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;

    logic              w_out_valid;
    logic              w_skid_valid;
    fetch_entry_t      w_out;
    fetch_entry_t      w_push_data;
    logic              w_push;
    logic              w_pop;
    logic [1:0]        w_occ;
    logic [1:0]        w_level;
    logic              w_room;
    logic              w_issue;

    assign w_pop   = w_out_valid && bus.dec_ready;
    assign w_occ   = {1'b0, w_out_valid} + {1'b0, w_skid_valid} + {1'b0, req_q};
    assign w_level = w_occ - {1'b0, w_pop};
    assign w_room  = (w_level < 2'd2);

`ifdef FETCH_FAULT_CHECK_EN
    localparam logic [ADDR_W-1:0] LAST_WORD_PC = ADDR_W'(MEM_BYTES - 4);

    logic fault_q, fault_d;
    logic w_try;
    logic w_bad_pc;

    assign w_bad_pc = (pc_q[1:0] != 2'b00) || (pc_q > LAST_WORD_PC);
    assign w_try    = fetch_en && !redirect_valid && w_room && !fault_q;
    assign w_issue  = w_try && !w_bad_pc;
    assign fault_d  = redirect_valid ? 1'b0 : (fault_q || (w_try && w_bad_pc));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fetch_fault = fault_q;
`else
    logic [31:0] w_unused_mem_bytes;

    assign w_unused_mem_bytes = 32'(MEM_BYTES);
    assign w_issue            = fetch_en && !redirect_valid && w_room;
`endif

    always_comb begin
        pc_d     = pc_q;
        req_d    = 1'b0;
        req_pc_d = req_pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (w_issue) begin
            req_d    = 1'b1;
            req_pc_d = pc_q;
            pc_d     = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            req_pc_q <= RESET_PC;
        end else begin
            pc_q     <= pc_d;
            req_q    <= req_d;
            req_pc_q <= req_pc_d;
        end
    end

    // A response arriving on a redirect edge belongs to the old path.
    assign w_push      = req_q && !redirect_valid;
    assign w_push_data = '{instr: bus.imem_data, pc: req_pc_q};

    fetch_skid_buffer u_skid (
        .clock        (clock),
        .reset        (reset),
        .flush_i      (redirect_valid),
        .push_i       (w_push),
        .push_data_i  (w_push_data),
        .ready_i      (bus.dec_ready),
        .valid_o      (w_out_valid),
        .data_o       (w_out),
        .skid_valid_o (w_skid_valid)
    );

    assign bus.imem_addr    = pc_q;
    assign bus.dec_valid    = w_out_valid;
    assign bus.dec_instr    = w_out.instr;
    assign bus.dec_pc       = w_out.pc;
    assign bus.dec_pc_plus4 = w_out.pc + PC_STEP;

endmodule : instruction_fetch

`default_nettype wire
